tblock_dispatcher: RTL and testbench
====================================

TBLOCK_DISPATCHER -- requirements
Module: tblock_dispatcher

Interface
REQ-001 The block SHALL have parameter PcWidth, default 32, program-counter width.
REQ-002 The block SHALL have parameter AddressWidth, default 32, data/parameter address width.
REQ-003 The block SHALL have parameter TblockIdxBits, default 4, thread-block index width; a job holds at most 2**TblockIdxBits blocks.
REQ-004 The block SHALL have parameter TblockIdBits, default 4, in-flight block identifier width; at most 2**TblockIdBits blocks are in flight.
REQ-005 The block SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 The block SHALL have ports job_valid_i  in  1  job offered; job_ready_o  out  1  job accepted.
REQ-007 The block SHALL have ports job_pc_i  in  PcWidth  start PC; job_dp_addr_i  in  AddressWidth  data/parameter address.
REQ-008 The block SHALL have port job_num_tblocks_i  in  TblockIdxBits+1  number of blocks in the job.
REQ-009 The block SHALL have port warp_free_i  in  1  the compute unit can accept a block this cycle.
REQ-010 The block SHALL have ports allocate_warp_o  out  1  block allocation; allocate_pc_o  out  PcWidth; allocate_dp_addr_o  out  AddressWidth; allocate_tblock_idx_o  out  TblockIdxBits; allocate_tblock_id_o  out  TblockIdBits.
REQ-011 The block SHALL have ports tblock_done_i  in  1  block completion; tblock_done_id_i  in  TblockIdBits  completed block id; tblock_done_ready_o  out  1  completion accepted.
REQ-012 The block SHALL have ports job_done_o  out  1  job complete; job_done_ready_i  in  1  completion acknowledged; busy_o  out  1  state is not IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, DISPATCH, DRAIN and DONE.
REQ-014 In IDLE the block SHALL assert job_ready_o. On job_valid_i it SHALL latch pc, dp_addr and num, and go to DONE if num==0, otherwise to DISPATCH.
REQ-015 The block SHALL hold a registered issue counter, a registered done counter (both TblockIdxBits+1 bits, cleared on job accept) and a registered id-busy bitmap (2**TblockIdBits bits).
REQ-016 In DISPATCH the block SHALL drive allocate_warp_o = warp_free_i && (bitmap has a zero bit), combinationally in the same cycle.
REQ-017 The allocation SHALL be a single-cycle transfer: allocate_warp_o high means the compute unit takes the block that cycle.
REQ-018 allocate_tblock_id_o SHALL be the lowest-index zero bit of the registered bitmap.
REQ-019 allocate_tblock_idx_o SHALL be issue_counter[TblockIdxBits-1:0].
REQ-020 allocate_pc_o and allocate_dp_addr_o SHALL be the latched job values.
REQ-021 On each allocation the block SHALL set the chosen bitmap bit and increment the issue counter.
REQ-022 When the incremented issue counter equals num, the block SHALL go to DRAIN.
REQ-023 In DISPATCH and DRAIN the block SHALL assert tblock_done_ready_o.
REQ-024 On tblock_done_i && tblock_done_ready_o the block SHALL clear bitmap bit tblock_done_id_i and increment the done counter.
REQ-025 When the incremented done counter equals num, the block SHALL go to DONE; this is reachable only from DRAIN.
REQ-026 When a completion and an allocation occur in the same cycle, both SHALL take effect; an id freed in a cycle SHALL NOT be reallocated in that same cycle.
REQ-027 With all ids busy, allocate_warp_o SHALL stay 0 until a completion frees an id.
REQ-028 In DONE the block SHALL assert job_done_o; on job_done_ready_i it SHALL go to IDLE, so a new job is acceptable the following cycle.
REQ-029 tblock_done_ready_o SHALL be 0 in IDLE and DONE.
REQ-030 A tblock_done_i whose id bit is clear SHALL be flagged by a simulation assertion and SHALL NOT change state.

Reset
REQ-031 While rst_i is high at a clock edge, the FSM SHALL go to IDLE and the counters, bitmap and latched job registers SHALL be cleared.
REQ-032 After reset the outputs SHALL be: job_ready_o=1, busy_o=0, allocate_warp_o=0, tblock_done_ready_o=0, job_done_o=0, and all data outputs 0.
REQ-033 Reset asserted mid-job SHALL abandon the job, and no further allocate or done pulses SHALL occur.

Verification
REQ-034 Bench SHALL cover: num=3, warp_free_i=1 constantly -> allocations on three consecutive cycles with idx 0,1,2 and id 0,1,2, then DRAIN; done ids 1,0,2 -> job_done_o in the cycle after the third done.
REQ-035 Bench SHALL cover: num=0 -> job_done_o=1 one cycle after accept, with no allocate_warp_o pulse.
REQ-036 Bench SHALL cover: TblockIdBits=1, num=4 -> two allocations (ids 0,1) then a stall; done id 0 -> the next allocation uses id 0 one cycle later, not in the done cycle.
REQ-037 Bench SHALL cover: warp_free_i toggling 1,0,1 with num=2 -> allocations only in the cycles where it is 1, idx 0 then 1.
REQ-038 Bench SHALL cover: job_done_ready_i held low 5 cycles -> job_done_o stays 1, job_ready_o stays 0; released -> job_ready_o=1 the next cycle.
REQ-039 Bench SHALL cover: rst_i pulsed after 2 of 4 allocations -> the REQ-032 reset values hold and a new job with num=1 allocates idx 0, id 0.

Source files
------------

// File: rtl/tblock_dispatcher.sv
// tblock_dispatcher
// Accepts one job at a time and splits it into thread blocks. Each block is
// handed to the compute unit with a job-relative index and a free in-flight
// id. Ids are recycled as blocks complete. Once every block of the job has
// completed, the job is reported done.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   job_valid_i/job_ready_o  job handshake: pc, dp_addr, number of blocks
//   warp_free_i              compute unit can take a block this cycle
//   allocate_*               single-cycle block allocation: pc, dp_addr, idx, id
//   tblock_done_*            block completion handshake carrying the freed id
//   job_done_o/_ready_i      job completion handshake
//   busy_o                   dispatcher is not idle
module tblock_dispatcher #(
    parameter int unsigned PcWidth       = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TblockIdxBits = 4,
    parameter int unsigned TblockIdBits  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [PcWidth-1:0]       job_pc_i,
    input  logic [AddressWidth-1:0]  job_dp_addr_i,
    input  logic [TblockIdxBits:0]   job_num_tblocks_i,
    input  logic                     warp_free_i,
    output logic                     allocate_warp_o,
    output logic [PcWidth-1:0]       allocate_pc_o,
    output logic [AddressWidth-1:0]  allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
    output logic [TblockIdBits-1:0]  allocate_tblock_id_o,
    input  logic                     tblock_done_i,
    input  logic [TblockIdBits-1:0]  tblock_done_id_i,
    output logic                     tblock_done_ready_o,
    output logic                     job_done_o,
    input  logic                     job_done_ready_i,
    output logic                     busy_o
);

    localparam int unsigned NumIds = 2 ** TblockIdBits;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                   state, state_next;
    logic [PcWidth-1:0]       job_pc;
    logic [AddressWidth-1:0]  job_dp_addr;
    logic [TblockIdxBits:0]   job_num;
    logic [TblockIdxBits:0]   issue_count, issue_inc;
    logic [TblockIdxBits:0]   done_count, done_inc;
    logic [NumIds-1:0]        id_busy, id_busy_next;
    logic [TblockIdBits-1:0]  free_id;
    logic                     have_free;
    logic                     accept;
    logic                     done_fire;

    assign issue_inc = issue_count + (TblockIdxBits + 1)'(1);
    assign done_inc  = done_count + (TblockIdxBits + 1)'(1);

    // Lowest free id, taken from the registered bitmap so an id released
    // this cycle only becomes allocatable on the next one.
    always_comb begin
        free_id   = '0;
        have_free = 1'b0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            if (!id_busy[i] && !have_free) begin
                free_id   = TblockIdBits'(i);
                have_free = 1'b1;
            end
        end
    end

    assign tblock_done_ready_o = (state == DISPATCH) || (state == DRAIN);
    // Completions for ids that are not in flight are ignored.
    assign done_fire = tblock_done_i && tblock_done_ready_o && id_busy[tblock_done_id_i];

    always_comb begin
        state_next      = state;
        job_ready_o     = 1'b0;
        job_done_o      = 1'b0;
        allocate_warp_o = 1'b0;
        accept          = 1'b0;
        case (state)
            IDLE: begin
                job_ready_o = 1'b1;
                if (job_valid_i) begin
                    accept     = 1'b1;
                    state_next = (job_num_tblocks_i == '0) ? DONE : DISPATCH;
                end
            end
            DISPATCH: begin
                allocate_warp_o = warp_free_i && have_free;
                if (allocate_warp_o && (issue_inc == job_num)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (done_fire && (done_inc == job_num)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                job_done_o = 1'b1;
                if (job_done_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        id_busy_next = id_busy;
        if (done_fire) begin
            id_busy_next[tblock_done_id_i] = 1'b0;
        end
        if (allocate_warp_o) begin
            id_busy_next[free_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            job_pc      <= '0;
            job_dp_addr <= '0;
            job_num     <= '0;
            issue_count <= '0;
            done_count  <= '0;
            id_busy     <= '0;
        end else begin
            state   <= state_next;
            id_busy <= id_busy_next;
            if (accept) begin
                job_pc      <= job_pc_i;
                job_dp_addr <= job_dp_addr_i;
                job_num     <= job_num_tblocks_i;
                issue_count <= '0;
                done_count  <= '0;
            end
            if (allocate_warp_o) begin
                issue_count <= issue_inc;
            end
            if (done_fire) begin
                done_count <= done_inc;
            end
        end
    end

    assign allocate_pc_o         = job_pc;
    assign allocate_dp_addr_o    = job_dp_addr;
    assign allocate_tblock_idx_o = issue_count[TblockIdxBits-1:0];
    assign allocate_tblock_id_o  = free_id;
    assign busy_o                = (state != IDLE);

    done_id_in_flight: assert property (@(posedge clk_i) disable iff (rst_i)
        (tblock_done_i && tblock_done_ready_o) |-> id_busy[tblock_done_id_i]);

endmodule

// File: tb/tb_tblock_dispatcher.sv
// Testbench for tblock_dispatcher. Two instances share clock and reset:
// dut_a uses default parameters, dut_b has a single id bit (two ids) to
// exercise id exhaustion. Stimulus pushes expected allocation and
// job-done events (with their cycle number) into per-instance queues; monitors
// pop and compare whenever an instance presents one of those events.
`timescale 1ns/1ps
module tb_tblock_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A
    logic        a_job_valid, a_job_ready, a_warp_free, a_alloc;
    logic [31:0] a_pc, a_dp, a_alloc_pc, a_alloc_dp;
    logic [4:0]  a_num;
    logic [3:0]  a_alloc_idx, a_alloc_id, a_done_id;
    logic        a_done, a_done_ready, a_job_done, a_job_done_ready, a_busy;

    // instance B
    logic        b_job_valid, b_job_ready, b_warp_free, b_alloc;
    logic [31:0] b_pc, b_dp, b_alloc_pc, b_alloc_dp;
    logic [4:0]  b_num;
    logic [3:0]  b_alloc_idx;
    logic [0:0]  b_alloc_id, b_done_id;
    logic        b_done, b_done_ready, b_job_done, b_job_done_ready, b_busy;

    tblock_dispatcher dut_a (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(a_job_valid), .job_ready_o(a_job_ready),
        .job_pc_i(a_pc), .job_dp_addr_i(a_dp), .job_num_tblocks_i(a_num),
        .warp_free_i(a_warp_free), .allocate_warp_o(a_alloc),
        .allocate_pc_o(a_alloc_pc), .allocate_dp_addr_o(a_alloc_dp),
        .allocate_tblock_idx_o(a_alloc_idx), .allocate_tblock_id_o(a_alloc_id),
        .tblock_done_i(a_done), .tblock_done_id_i(a_done_id),
        .tblock_done_ready_o(a_done_ready),
        .job_done_o(a_job_done), .job_done_ready_i(a_job_done_ready),
        .busy_o(a_busy)
    );

    tblock_dispatcher #(.TblockIdBits(1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(b_job_valid), .job_ready_o(b_job_ready),
        .job_pc_i(b_pc), .job_dp_addr_i(b_dp), .job_num_tblocks_i(b_num),
        .warp_free_i(b_warp_free), .allocate_warp_o(b_alloc),
        .allocate_pc_o(b_alloc_pc), .allocate_dp_addr_o(b_alloc_dp),
        .allocate_tblock_idx_o(b_alloc_idx), .allocate_tblock_id_o(b_alloc_id),
        .tblock_done_i(b_done), .tblock_done_id_i(b_done_id),
        .tblock_done_ready_o(b_done_ready),
        .job_done_o(b_job_done), .job_done_ready_i(b_job_done_ready),
        .busy_o(b_busy)
    );

    int vectors = 0;
    int misses  = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    function automatic void cmp(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // event word: {kind(1=job done), cycle, pc, idx, id}
    function automatic logic [63:0] pack(logic d, int c, logic [31:0] p, logic [3:0] x, logic [3:0] i);
        return {7'b0, d, c[15:0], p, x, i};
    endfunction

    function automatic void note_a(logic [63:0] got);
        if (qa.size() == 0) begin
            vectors++;
            misses++;
            $display("FAIL a_event: got %0h, expected no event", got);
        end else begin
            cmp("a_event", got, qa.pop_front());
        end
    endfunction

    function automatic void note_b(logic [63:0] got);
        if (qb.size() == 0) begin
            vectors++;
            misses++;
            $display("FAIL b_event: got %0h, expected no event", got);
        end else begin
            cmp("b_event", got, qb.pop_front());
        end
    endfunction

    logic a_done_q = 1'b0;
    logic b_done_q = 1'b0;

    always @(negedge clk) begin
        if (a_alloc) note_a(pack(1'b0, cyc, a_alloc_pc, a_alloc_idx, a_alloc_id));
        if (a_job_done && !a_done_q) note_a(pack(1'b1, cyc, '0, '0, '0));
        a_done_q = a_job_done;
    end

    always @(negedge clk) begin
        if (b_alloc) note_b(pack(1'b0, cyc, b_alloc_pc, b_alloc_idx, {3'b0, b_alloc_id}));
        if (b_job_done && !b_done_q) note_b(pack(1'b1, cyc, '0, '0, '0));
        b_done_q = b_job_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_reset_a(string tag);
        cmp({tag, "_a_job_ready"},  a_job_ready, 1);
        cmp({tag, "_a_busy"},       a_busy, 0);
        cmp({tag, "_a_alloc"},      a_alloc, 0);
        cmp({tag, "_a_done_ready"}, a_done_ready, 0);
        cmp({tag, "_a_job_done"},   a_job_done, 0);
        cmp({tag, "_a_pc"},         a_alloc_pc, 0);
        cmp({tag, "_a_dp"},         a_alloc_dp, 0);
        cmp({tag, "_a_idx"},        a_alloc_idx, 0);
        cmp({tag, "_a_id"},         a_alloc_id, 0);
    endtask

    int k;

    initial begin
        rst = 1'b1;
        a_job_valid = 0; a_pc = '0; a_dp = '0; a_num = '0; a_warp_free = 0;
        a_done = 0; a_done_id = '0; a_job_done_ready = 0;
        b_job_valid = 0; b_pc = '0; b_dp = '0; b_num = '0; b_warp_free = 0;
        b_done = 0; b_done_id = '0; b_job_done_ready = 0;
        repeat (3) step();
        rst = 1'b0;
        sample();
        check_reset_a("rst");
        cmp("rst_b_job_ready", b_job_ready, 1);
        cmp("rst_b_done_ready", b_done_ready, 0);

        // num=3, warp always free; completions 1,0,2; job-done ack held off 5 cycles
        step(); k = cyc;
        a_job_valid = 1; a_num = 3; a_pc = 32'h1000; a_dp = 32'h2000; a_warp_free = 1;
        qa.push_back(pack(1'b0, k + 1, 32'h1000, 4'd0, 4'd0));
        qa.push_back(pack(1'b0, k + 2, 32'h1000, 4'd1, 4'd1));
        qa.push_back(pack(1'b0, k + 3, 32'h1000, 4'd2, 4'd2));
        qa.push_back(pack(1'b1, k + 7, '0, '0, '0));
        sample();
        cmp("s1_job_ready", a_job_ready, 1);
        step(); a_job_valid = 0; a_pc = '0; a_dp = '0;
        sample();
        cmp("s1_busy", a_busy, 1);
        cmp("s1_dp_latched", a_alloc_dp, 32'h2000);
        step(); step();
        step(); a_done = 1; a_done_id = 4'd1;
        sample();
        cmp("s1_drain_done_ready", a_done_ready, 1);
        cmp("s1_drain_no_alloc", a_alloc, 0);
        step(); a_done_id = 4'd0;
        step(); a_done_id = 4'd2;
        step(); a_done = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            cmp("s1_hold_job_done", a_job_done, 1);
            cmp("s1_hold_job_ready", a_job_ready, 0);
            step();
        end
        a_job_done_ready = 1;
        sample();
        cmp("s1_job_done_at_ack", a_job_done, 1);
        step(); a_job_done_ready = 0;
        sample();
        cmp("s1_idle_job_ready", a_job_ready, 1);
        cmp("s1_idle_busy", a_busy, 0);

        // num=0: done one cycle after accept, no allocation
        step(); k = cyc;
        a_job_valid = 1; a_num = 0; a_pc = 32'hABC0; a_dp = 32'hDEAD;
        qa.push_back(pack(1'b1, k + 1, '0, '0, '0));
        step(); a_job_valid = 0; a_job_done_ready = 1;
        sample();
        cmp("s2_job_done", a_job_done, 1);
        cmp("s2_done_ready_low", a_done_ready, 0);
        step(); a_job_done_ready = 0;
        sample();
        cmp("s2_job_ready", a_job_ready, 1);

        // num=2 with warp_free toggling 1,0,1
        step(); k = cyc;
        a_job_valid = 1; a_num = 2; a_pc = 32'h3000; a_dp = 32'h4000; a_warp_free = 0;
        qa.push_back(pack(1'b0, k + 1, 32'h3000, 4'd0, 4'd0));
        qa.push_back(pack(1'b0, k + 3, 32'h3000, 4'd1, 4'd1));
        qa.push_back(pack(1'b1, k + 6, '0, '0, '0));
        step(); a_job_valid = 0; a_warp_free = 1;
        step(); a_warp_free = 0;
        sample();
        cmp("s4_no_alloc_warp_busy", a_alloc, 0);
        step(); a_warp_free = 1;
        step(); a_done = 1; a_done_id = 4'd0;
        step(); a_done_id = 4'd1;
        step(); a_done = 0; a_job_done_ready = 1;
        step(); a_job_done_ready = 0;

        // two ids only, num=4: stall, freed id reused one cycle after its completion
        step(); k = cyc;
        b_job_valid = 1; b_num = 4; b_pc = 32'h6000; b_dp = 32'h6100; b_warp_free = 1;
        qb.push_back(pack(1'b0, k + 1, 32'h6000, 4'd0, 4'd0));
        qb.push_back(pack(1'b0, k + 2, 32'h6000, 4'd1, 4'd1));
        qb.push_back(pack(1'b0, k + 4, 32'h6000, 4'd2, 4'd0));
        qb.push_back(pack(1'b0, k + 6, 32'h6000, 4'd3, 4'd1));
        qb.push_back(pack(1'b1, k + 9, '0, '0, '0));
        step(); b_job_valid = 0;
        step();
        step(); b_done = 1; b_done_id = 1'b0;
        sample();
        cmp("s3_no_alloc_in_done_cycle", b_alloc, 0);
        step(); b_done = 0;
        step(); b_done = 1; b_done_id = 1'b1;
        sample();
        cmp("s3_no_alloc_all_busy", b_alloc, 0);
        step(); b_done = 0;
        step(); b_done = 1; b_done_id = 1'b0;
        step(); b_done_id = 1'b1;
        step(); b_done = 0; b_job_done_ready = 1;
        step(); b_job_done_ready = 0;

        // reset after 2 of 4 allocations, then a fresh num=1 job
        step(); k = cyc;
        a_job_valid = 1; a_num = 4; a_pc = 32'h7000; a_dp = 32'h8000; a_warp_free = 1;
        qa.push_back(pack(1'b0, k + 1, 32'h7000, 4'd0, 4'd0));
        qa.push_back(pack(1'b0, k + 2, 32'h7000, 4'd1, 4'd1));
        step(); a_job_valid = 0;
        step();
        step(); rst = 1; a_warp_free = 0;
        step(); rst = 0; a_warp_free = 1;
        sample();
        check_reset_a("s5");
        step(); k = cyc;
        a_job_valid = 1; a_num = 1; a_pc = 32'h9000; a_dp = 32'h9100;
        qa.push_back(pack(1'b0, k + 1, 32'h9000, 4'd0, 4'd0));
        qa.push_back(pack(1'b1, k + 3, '0, '0, '0));
        step(); a_job_valid = 0;
        sample();
        cmp("s5_new_dp", a_alloc_dp, 32'h9100);
        step(); a_done = 1; a_done_id = 4'd0;
        step(); a_done = 0; a_job_done_ready = 1;
        step(); a_job_done_ready = 0;
        repeat (3) step();

        cmp("a_queue_drained", qa.size(), 0);
        cmp("b_queue_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
